// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: runs loads/stores over a req/ack bus,
// stalls upstream while busy and presents the MEM bundle to MEM/WB.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_rf_we,
  input  logic [1:0]  ex_wd_sel,
  input  logic [4:0]  ex_wR,
  input  logic [31:0] ex_sext,
  input  logic [31:0] ex_rD2,
  input  logic [31:0] ex_alu_c,
  input  logic [31:0] ex_pc,
  input  logic        ex_mem_re,
  input  logic        ex_mem_we,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_uns,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_rf_we,
  output logic [1:0]  mem_wd_sel,
  output logic [4:0]  mem_wR,
  output logic [31:0] mem_sext,
  output logic [31:0] mem_rD2,
  output logic [31:0] mem_alu_c,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_dram_rd,
  output logic        mem_misalign,
  output logic        mem_bus_err
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            timed_out;
  logic [31:0]     rdata_q;
  logic            acc, misalign_c;
  logic [31:0]     wdata_c;
  logic [3:0]      wstrb_c;
  logic [31:0]     load_c;
  logic [31:0]     shifted_c;

  assign acc = ex_mem_re | ex_mem_we;
  assign misalign_c = ((ex_mem_size == 2'b01) && ex_alu_c[0]) ||
                      (ex_mem_size[1] && (ex_alu_c[1:0] != 2'b00));

  // Store lane replication and byte strobes
  always_comb begin
    wdata_c = ex_rD2;
    wstrb_c = 4'b1111;
    case (ex_mem_size)
      2'b00: begin
        wdata_c = {4{ex_rD2[7:0]}};
        wstrb_c = 4'(4'b0001 << ex_alu_c[1:0]);
      end
      2'b01: begin
        wdata_c = {2{ex_rD2[15:0]}};
        wstrb_c = 4'(4'b0011 << {ex_alu_c[1], 1'b0});
      end
      default: ;
    endcase
  end

  // Load lane selection and extension from the captured word
  always_comb begin
    shifted_c = rdata_q;
    load_c    = rdata_q;
    case (ex_mem_size)
      2'b00: begin
        shifted_c = rdata_q >> {ex_alu_c[1:0], 3'b000};
        load_c    = {{24{shifted_c[7] & ~ex_mem_uns}}, shifted_c[7:0]};
      end
      2'b01: begin
        shifted_c = rdata_q >> {ex_alu_c[1], 4'b0000};
        load_c    = {{16{shifted_c[15] & ~ex_mem_uns}}, shifted_c[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, stall and bubble insertion
  always_comb begin
    state_nx     = state;
    stall        = 1'b0;
    mem_rf_we    = ex_rf_we;
    mem_dram_rd  = '0;
    mem_misalign = 1'b0;
    mem_bus_err  = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          mem_rf_we = 1'b0;
          if (misalign_c) begin
            mem_misalign = 1'b1;
          end else begin
            stall    = 1'b1;
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        stall     = 1'b1;
        mem_rf_we = 1'b0;
        if (dbus_ack || (cnt == CNT_LAST)) state_nx = DONE;
      end
      DONE: begin
        mem_dram_rd = load_c;
        mem_rf_we   = ex_rf_we & ~timed_out;
        mem_bus_err = timed_out;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus registers, timeout counter and read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      dbus_wstrb <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && !misalign_c) begin
            dbus_req   <= 1'b1;
            dbus_we    <= ex_mem_we;
            dbus_addr  <= {ex_alu_c[31:2], 2'b00};
            dbus_wdata <= wdata_c;
            dbus_wstrb <= ex_mem_we ? wstrb_c : 4'b0000;
            cnt        <= '0;
            timed_out  <= 1'b0;
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            rdata_q  <= dbus_rdata;
          end else if (cnt == CNT_LAST) begin
            dbus_req  <= 1'b0;
            timed_out <= 1'b1;
            rdata_q   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          cnt       <= '0;
          timed_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_wd_sel = ex_wd_sel;
  assign mem_wR     = ex_wR;
  assign mem_sext   = ex_sext;
  assign mem_rD2    = ex_rD2;
  assign mem_alu_c  = ex_alu_c;
  assign mem_pc     = ex_pc;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM bundles are queued at
// issue and compared when the stage reports completion.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_rf_we;
  logic [1:0]  ex_wd_sel;
  logic [4:0]  ex_wR;
  logic [31:0] ex_sext, ex_rD2, ex_alu_c, ex_pc;
  logic        ex_mem_re, ex_mem_we;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_uns;
  logic        stall, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_rf_we;
  logic [1:0]  mem_wd_sel;
  logic [4:0]  mem_wR;
  logic [31:0] mem_sext, mem_rD2, mem_alu_c, mem_pc, mem_dram_rd;
  logic        mem_misalign, mem_bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk_dram;
    logic [31:0] dram;
    logic        rf_we;
    logic        bus_err;
    logic        misalign;
    int          stalls;
    int          reqs;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic [31:0] alu_c;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_rf_we(ex_rf_we), .ex_wd_sel(ex_wd_sel), .ex_wR(ex_wR),
    .ex_sext(ex_sext), .ex_rD2(ex_rD2), .ex_alu_c(ex_alu_c), .ex_pc(ex_pc),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_mem_size(ex_mem_size), .ex_mem_uns(ex_mem_uns),
    .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_rf_we(mem_rf_we), .mem_wd_sel(mem_wd_sel), .mem_wR(mem_wR),
    .mem_sext(mem_sext), .mem_rD2(mem_rD2), .mem_alu_c(mem_alu_c),
    .mem_pc(mem_pc), .mem_dram_rd(mem_dram_rd),
    .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) begin
      case (a[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (size == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (size == 2'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] size,
                                             input logic uns, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*a[1:0] +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    if (size == 2'd0) return uns ? {24'd0, b} : {{24{b[7]}}, b};
    if (size == 2'd1) return uns ? {16'd0, h} : {{16{h[15]}}, h};
    return d;
  endfunction

  task automatic drive_idle();
    ex_mem_re = 1'b0;
    ex_mem_we = 1'b0;
  endtask

  // Issues one instruction, plays the bus slave, compares at completion.
  // ack_after < 0 means the slave never acknowledges.
  task automatic run_op(input string name, input logic re, input logic we,
                        input logic [1:0] size, input logic uns, input logic [31:0] a,
                        input logic [31:0] rd2, input int ack_after,
                        input logic [31:0] rdata, input logic late_ack);
    exp_t e, g;
    int stalls, reqs, guard;
    logic acc, mis, seen_bus;
    @(posedge clk); #1;
    ex_rf_we = 1'b1; ex_wd_sel = 2'b01; ex_wR = 5'($urandom_range(1, 31));
    ex_sext = $urandom; ex_rD2 = rd2; ex_alu_c = a; ex_pc = $urandom;
    ex_mem_re = re; ex_mem_we = we; ex_mem_size = size; ex_mem_uns = uns;
    acc = re | we;
    mis = acc && is_misaligned(size, a);
    e.misalign  = mis;
    e.bus_err   = acc && !mis && (ack_after < 0);
    e.rf_we     = !(mis || e.bus_err);
    e.chk_dram  = !e.bus_err;
    e.dram      = (acc && !mis) ? model_load(rdata, size, uns, a) : 32'd0;
    e.reqs      = (!acc || mis) ? 0 : ((ack_after < 0) ? 16 : ack_after + 1);
    e.stalls    = (e.reqs == 0) ? 0 : e.reqs + 1;
    e.addr      = {a[31:2], 2'b00};
    e.we        = we;
    e.strb      = we ? model_strb(size, a) : 4'b0000;
    e.chk_wdata = we;
    e.wdata     = model_wdata(size, rd2);
    e.alu_c     = a;
    e.pc        = ex_pc;
    sb.push_back(e);
    stalls = 0; reqs = 0; guard = 0; seen_bus = 1'b0;
    @(negedge clk);
    while (stall && guard < 100) begin
      stalls++;
      if (mem_rf_we !== 1'b0) begin
        errors++; $display("FAIL %s bubble: mem_rf_we=%b required 0", name, mem_rf_we);
      end
      checks++;
      if (dbus_req) begin
        reqs++;
        if (!seen_bus) begin
          seen_bus = 1'b1;
          if (dbus_addr !== e.addr || dbus_we !== e.we || dbus_wstrb !== e.strb) begin
            errors++;
            $display("FAIL %s bus: addr=%h we=%b strb=%b required addr=%h we=%b strb=%b",
                     name, dbus_addr, dbus_we, dbus_wstrb, e.addr, e.we, e.strb);
          end
          checks++;
          if (e.chk_wdata) begin
            if (dbus_wdata !== e.wdata) begin
              errors++; $display("FAIL %s wdata: got %h required %h", name, dbus_wdata, e.wdata);
            end
            checks++;
          end
        end
        if (ack_after >= 0 && reqs == ack_after + 1) begin
          dbus_ack = 1'b1; dbus_rdata = rdata;
        end
      end
      @(posedge clk); #1;
      dbus_ack = 1'b0; dbus_rdata = $urandom;
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      errors++; $display("FAIL %s timeout: stall never released", name);
    end
    checks++;
    g = sb.pop_front();
    if (stalls !== g.stalls || reqs !== g.reqs) begin
      errors++; $display("FAIL %s timing: stalls=%0d reqs=%0d required stalls=%0d reqs=%0d",
                         name, stalls, reqs, g.stalls, g.reqs);
    end
    checks++;
    if (mem_rf_we !== g.rf_we || mem_misalign !== g.misalign || mem_bus_err !== g.bus_err) begin
      errors++; $display("FAIL %s flags: rf_we=%b misalign=%b bus_err=%b required %b %b %b",
                         name, mem_rf_we, mem_misalign, mem_bus_err, g.rf_we, g.misalign, g.bus_err);
    end
    checks++;
    if (g.chk_dram) begin
      if (mem_dram_rd !== g.dram) begin
        errors++; $display("FAIL %s dram_rd: got %h required %h", name, mem_dram_rd, g.dram);
      end
      checks++;
    end
    if (mem_alu_c !== g.alu_c || mem_pc !== g.pc || dbus_req !== 1'b0) begin
      errors++; $display("FAIL %s passthru: alu_c=%h pc=%h req=%b required %h %h 0",
                         name, mem_alu_c, mem_pc, dbus_req, g.alu_c, g.pc);
    end
    checks++;
    if (late_ack) begin
      dbus_ack = 1'b1; dbus_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      dbus_ack = 1'b0; drive_idle();
      @(negedge clk);
      if (dbus_req !== 1'b0 || stall !== 1'b0 || mem_bus_err !== 1'b0 || mem_dram_rd !== 32'd0) begin
        errors++; $display("FAIL %s late_ack: req=%b stall=%b bus_err=%b dram=%h required 0 0 0 0",
                           name, dbus_req, stall, mem_bus_err, mem_dram_rd);
      end
      checks++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    ex_rf_we = 1'b0; ex_wd_sel = '0; ex_wR = '0; ex_sext = '0; ex_rD2 = '0;
    ex_alu_c = '0; ex_pc = '0; ex_mem_size = 2'd2; ex_mem_uns = 1'b0; drive_idle();
    repeat (2) @(negedge clk);
    if (dbus_req !== 1'b0 || dbus_we !== 1'b0 || dbus_addr !== 32'd0 || dbus_wdata !== 32'd0 ||
        dbus_wstrb !== 4'd0 || stall !== 1'b0 || mem_misalign !== 1'b0 || mem_bus_err !== 1'b0 ||
        mem_dram_rd !== 32'd0) begin
      errors++; $display("FAIL reset: req=%b we=%b addr=%h wdata=%h strb=%b stall=%b required all 0",
                         dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, stall);
    end
    checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_op();
    run_op("alu", 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'h0, 0, 32'h0, 1'b0);
  endtask

  task automatic test_loads();
    run_op("lb_s", 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF00, 1'b0);
    run_op("lbu", 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'h0, 1, 32'h1122_F344, 1'b0);
    run_op("lh_s", 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0, 0, 32'h8001_7FFF, 1'b0);
    run_op("lhu", 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'h0, 2, 32'h1234_9ABC, 1'b0);
    run_op("lw", 1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_0400, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    run_op("lw_rsv", 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0404, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
  endtask

  task automatic test_stores();
    run_op("sh", 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'hAAAA_BEEF, 0, 32'h0, 1'b0);
    run_op("sb", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0105, 32'h1234_56A5, 1, 32'h0, 1'b0);
    run_op("sw", 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0108, 32'h0BAD_F00D, 0, 32'h0, 1'b0);
    run_op("re_we", 1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_010A, 32'h0000_0077, 0, 32'h0, 1'b0);
  endtask

  task automatic test_misalign();
    run_op("lw_mis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0201, 32'h0, 0, 32'h0, 1'b0);
    run_op("sh_mis", 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0203, 32'h5555_5555, 0, 32'h0, 1'b0);
  endtask

  task automatic test_timeout();
    run_op("lw_to", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, -1, 32'h0, 1'b1);
    run_op("after_to", 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0302, 32'h0, 0, 32'h00AB_0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_op("b2b", 1'b1, 1'b0, 2'd0, i[0], 32'h0000_0500 + 32'(i), 32'h0, 0, 32'h8899_AABB, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ex_alu_c = 32'h0000_0600; ex_mem_size = 2'd2; ex_mem_re = 1'b1; ex_mem_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (dbus_req !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL rst_mid busy: req=%b stall=%b required 1 1", dbus_req, stall);
    end
    checks++;
    #1; rst_n = 1'b0; drive_idle();
    #1;
    if (dbus_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_mid drop: req=%b stall=%b required 0 0", dbus_req, stall);
    end
    checks++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    if (dbus_req !== 1'b0 || dbus_we !== 1'b0 || dbus_addr !== 32'd0 || dbus_wdata !== 32'd0 ||
        dbus_wstrb !== 4'd0 || stall !== 1'b0 || mem_bus_err !== 1'b0 || mem_misalign !== 1'b0 ||
        mem_dram_rd !== 32'd0) begin
      errors++; $display("FAIL rst_mid after: req=%b we=%b addr=%h wdata=%h strb=%b stall=%b required all 0",
                         dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, stall);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard: %0d entries left required 0", sb.size());
    end
    checks++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
